// File: rtl/mmio_perf_counter_bank_if.sv
// Load/store bus between the CPU IO region and the performance counter bank.
// The CPU store path drives wr_*, the load path drives rd_* and samples
// rd_data/rd_hit one cycle later.
interface mmio_perf_counter_bank_if;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [31:0] rd_addr;
    logic [31:0] rd_data;
    logic        rd_hit;

    modport master (
        output wr_en, wr_addr, wr_data, rd_en, rd_addr,
        input  rd_data, rd_hit
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
        output rd_data, rd_hit
    );
endinterface

// File: rtl/mmio_perf_counter_bank.sv
// Memory-mapped bank of NUM_CNT event counters with a global enable, an
// atomic clear, sticky W1C overflow flags and tear-free 64-bit reads through
// per-counter high-word shadows captured on every CNT_LO read.
// Optional build macro PERF_CNT_SAT_EN: counters saturate at all-ones
// instead of wrapping; overflow is flagged either way.
module mmio_perf_counter_bank #(
    parameter int          NUM_CNT    = 8,
    parameter int          CNT_WIDTH  = 48,
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0040,
    parameter logic        RST_EN_VAL = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CNT-1:0]       inc_en,
    mmio_perf_counter_bank_if.slave  bus,
    output logic                     ovf_any
);

    localparam int          HI_W      = CNT_WIDTH - 32;
    localparam logic [31:0] WIN_BYTES = 32'(32 + 8 * NUM_CNT);
    localparam logic [31:0] ID_VAL    = {8'(CNT_WIDTH), 8'(NUM_CNT), 16'hC0DE};

    // ------------------------------------------------------------------
    // Address decode. Offsets are relative to BASE_ADDR; an address below
    // the base wraps to a huge offset and so falls outside the window.
    // ------------------------------------------------------------------
    logic [31:0] wr_off, rd_off;
    logic [31:0] wr_word, rd_word, rd_rel;
    logic        wr_in_win, rd_in_win;
    logic        wr_ctrl, wr_ovf;
    logic        rd_ctrl, rd_ovf, rd_id, rd_cnt_area;
    logic        clear_req;

    assign wr_off    = bus.wr_addr - BASE_ADDR;
    assign rd_off    = bus.rd_addr - BASE_ADDR;
    assign wr_word   = wr_off >> 2;
    assign rd_word   = rd_off >> 2;
    assign wr_in_win = (wr_off < WIN_BYTES);
    assign rd_in_win = (rd_off < WIN_BYTES);

    assign wr_ctrl   = bus.wr_en && wr_in_win && (wr_word == 32'd0);
    assign wr_ovf    = bus.wr_en && wr_in_win && (wr_word == 32'd1);
    assign clear_req = wr_ctrl && bus.wr_data[1];

    assign rd_ctrl     = bus.rd_en && rd_in_win && (rd_word == 32'd0);
    assign rd_ovf      = bus.rd_en && rd_in_win && (rd_word == 32'd1);
    assign rd_id       = bus.rd_en && rd_in_win && (rd_word == 32'd2);
    assign rd_cnt_area = bus.rd_en && rd_in_win && (rd_word >= 32'd8);
    // Word index within the counter area: even = LO, odd = HI.
    assign rd_rel      = rd_word - 32'd8;

    // ------------------------------------------------------------------
    // Shared state
    // ------------------------------------------------------------------
    logic                enable_q, enable_d;
    logic [NUM_CNT-1:0]  ovf_q, ovf_d;
    logic                ovf_any_q, ovf_any_d;
    logic [31:0]         rd_data_q, rd_data_d;
    logic                rd_hit_q, rd_hit_d;

    logic [NUM_CNT-1:0]                ovf_set;
    logic [NUM_CNT-1:0]                rd_lo_sel, rd_hi_sel;
    logic [NUM_CNT-1:0][CNT_WIDTH-1:0] cnt_all;
    logic [NUM_CNT-1:0][HI_W-1:0]      hi_all;

    // ------------------------------------------------------------------
    // Per-counter datapath: count, overflow detect, high-word shadow.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
            logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
            logic [HI_W-1:0]      hi_q, hi_d;
            logic                 ovf_hit;

            assign rd_lo_sel[gi] = rd_cnt_area && (rd_rel == 32'(2 * gi));
            assign rd_hi_sel[gi] = rd_cnt_area && (rd_rel == 32'(2 * gi + 1));

            // Next count: clear dominates, then the registered enable gates
            // the increment; all-ones either wraps or saturates.
            always_comb begin
                cnt_d   = cnt_q;
                ovf_hit = 1'b0;
                if (clear_req) begin
                    cnt_d = '0;
                end else if (enable_q && inc_en[gi]) begin
                    if (&cnt_q) begin
                        ovf_hit = 1'b1;
`ifdef PERF_CNT_SAT_EN
                        cnt_d = cnt_q;
`else
                        cnt_d = '0;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end
            end

            // High-word shadow: captured from the same pre-edge count that
            // the LO read returns, so a LO-then-HI pair never tears.
            always_comb begin
                hi_d = hi_q;
                if (clear_req) begin
                    hi_d = '0;
                end else if (rd_lo_sel[gi]) begin
                    hi_d = cnt_q[CNT_WIDTH-1:32];
                end
            end

            // Counter and shadow registers.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt_q <= '0;
                    hi_q  <= '0;
                end else begin
                    cnt_q <= cnt_d;
                    hi_q  <= hi_d;
                end
            end

            assign ovf_set[gi] = ovf_hit;
            assign cnt_all[gi] = cnt_q;
            assign hi_all[gi]  = hi_q;
        end
    endgenerate

    // Control and status next-state: enable follows CTRL writes, overflow
    // flags are sticky with W1C where a fresh overflow beats the clear.
    always_comb begin
        enable_d  = enable_q;
        ovf_d     = ovf_q;
        ovf_any_d = |ovf_q;
        if (wr_ctrl) begin
            enable_d = bus.wr_data[0];
        end
        if (clear_req) begin
            ovf_d = '0;
        end else begin
            if (wr_ovf) begin
                ovf_d = ovf_d & ~bus.wr_data[NUM_CNT-1:0];
            end
            ovf_d = ovf_d | ovf_set;
        end
    end

    // Read mux: all sources are pre-edge register values, so a read that
    // coincides with a write or clear returns the old contents.
    always_comb begin
        rd_data_d = rd_data_q;
        rd_hit_d  = 1'b0;
        if (bus.rd_en) begin
            rd_data_d = '0;
            if (rd_ctrl) begin
                rd_data_d = {31'd0, enable_q};
                rd_hit_d  = 1'b1;
            end
            if (rd_ovf) begin
                rd_data_d = 32'(ovf_q);
                rd_hit_d  = 1'b1;
            end
            if (rd_id) begin
                rd_data_d = ID_VAL;
                rd_hit_d  = 1'b1;
            end
            for (int i = 0; i < NUM_CNT; i++) begin
                if (rd_lo_sel[i]) begin
                    rd_data_d = cnt_all[i][31:0];
                    rd_hit_d  = 1'b1;
                end
                if (rd_hi_sel[i]) begin
                    rd_data_d = 32'(hi_all[i]);
                    rd_hit_d  = 1'b1;
                end
            end
        end
    end

    // Control, status and read-response registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            enable_q  <= RST_EN_VAL;
            ovf_q     <= '0;
            ovf_any_q <= 1'b0;
            rd_data_q <= '0;
            rd_hit_q  <= 1'b0;
        end else begin
            enable_q  <= enable_d;
            ovf_q     <= ovf_d;
            ovf_any_q <= ovf_any_d;
            rd_data_q <= rd_data_d;
            rd_hit_q  <= rd_hit_d;
        end
    end

    assign bus.rd_data = rd_data_q;
    assign bus.rd_hit  = rd_hit_q;
    assign ovf_any     = ovf_any_q;

endmodule

// File: tb/tb_mmio_perf_counter_bank.sv
// Directed bench for mmio_perf_counter_bank (default parameters).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mmio_perf_counter_bank;

    localparam logic [31:0] BASE = 32'h8000_0040;

    logic       clk;
    logic       rst;
    logic [7:0] inc_en;
    logic       ovf_any;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] d;
    logic        h;

    mmio_perf_counter_bank_if bus();

    mmio_perf_counter_bank dut (
        .clk     (clk),
        .rst     (rst),
        .inc_en  (inc_en),
        .bus     (bus),
        .ovf_any (ovf_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] lo_addr(input int i);
        return BASE + 32'h20 + 32'(8 * i);
    endfunction

    function automatic logic [31:0] hi_addr(input int i);
        return BASE + 32'h24 + 32'(8 * i);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            $display("chk  %s: got %0h", tag, got);
        end
    endtask

    // One store; starts and ends on a falling edge.
    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = addr;
        bus.wr_data = data;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    // One load; the response is registered on the rising edge in between.
    task automatic rd(input logic [31:0] addr, output logic [31:0] data, output logic hit);
        bus.rd_en   = 1'b1;
        bus.rd_addr = addr;
        @(negedge clk);
        data        = bus.rd_data;
        hit         = bus.rd_hit;
        bus.rd_en   = 1'b0;
    endtask

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.rd_en   = 1'b0;
        bus.rd_addr = '0;
        inc_en      = '0;
        rst         = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_rd_data", 64'(bus.rd_data), 64'h0);
        check("rst_rd_hit", 64'(bus.rd_hit), 64'h0);
        check("rst_ovf_any", 64'(ovf_any), 64'h0);
        rst = 1'b1;
        @(negedge clk);

        // ID, unmapped, out-of-window, CTRL reset value, hold behaviour
        rd(BASE + 32'h08, d, h);
        check("id_data", 64'(d), 64'h3008_C0DE);
        check("id_hit", 64'(h), 64'h1);
        rd(BASE + 32'h10, d, h);
        check("unmapped_data", 64'(d), 64'h0);
        check("unmapped_hit", 64'(h), 64'h0);
        rd(BASE + 32'h100, d, h);
        check("outwin_data", 64'(d), 64'h0);
        check("outwin_hit", 64'(h), 64'h0);
        rd(BASE, d, h);
        check("ctrl_rst_en", 64'(d), 64'h1);
        @(negedge clk);
        check("hold_data", 64'(bus.rd_data), 64'h1);
        check("hold_hit", 64'(bus.rd_hit), 64'h0);

        // 100 increments on counter 2
        inc_en = 8'h04;
        repeat (100) @(negedge clk);
        inc_en = 8'h00;
        rd(lo_addr(2), d, h);
        check("cnt2_lo_100", 64'(d), 64'd100);
        rd(hi_addr(2), d, h);
        check("cnt2_hi_0", 64'(d), 64'h0);
        rd(lo_addr(0), d, h);
        check("cnt0_lo_0", 64'(d), 64'h0);
        rd(lo_addr(7), d, h);
        check("cnt7_lo_0", 64'(d), 64'h0);

        // Simultaneous CTRL read and write returns the pre-write value
        bus.wr_en   = 1'b1;
        bus.wr_addr = BASE;
        bus.wr_data = 32'h0;
        bus.rd_en   = 1'b1;
        bus.rd_addr = BASE;
        @(negedge clk);
        check("ctrl_rw_old", 64'(bus.rd_data), 64'h1);
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;

        // Disabled: pulses are ignored
        inc_en = 8'h04;
        repeat (5) @(negedge clk);
        inc_en = 8'h00;
        rd(lo_addr(2), d, h);
        check("cnt2_disabled", 64'(d), 64'd100);
        rd(BASE, d, h);
        check("ctrl_en_0", 64'(d), 64'h0);
        wr(BASE, 32'h1);

        // Carry into the high word and shadow hold
        force dut.g_cnt[1].cnt_q = 48'h0000_FFFF_FFFF;
        #1;
        release dut.g_cnt[1].cnt_q;
        @(negedge clk);
        inc_en = 8'h02;
        @(negedge clk);
        inc_en = 8'h00;
        rd(lo_addr(1), d, h);
        check("cnt1_lo_carry", 64'(d), 64'h0);
        rd(hi_addr(1), d, h);
        check("cnt1_hi_carry", 64'(d), 64'h1);
        force dut.g_cnt[1].cnt_q = 48'h0002_0000_0005;
        #1;
        release dut.g_cnt[1].cnt_q;
        @(negedge clk);
        rd(hi_addr(1), d, h);
        check("cnt1_hi_held", 64'(d), 64'h1);
        rd(lo_addr(1), d, h);
        check("cnt1_lo_new", 64'(d), 64'h5);
        rd(hi_addr(1), d, h);
        check("cnt1_hi_new", 64'(d), 64'h2);
        rd(BASE + 32'h04, d, h);
        check("ovf_none", 64'(d), 64'h0);

        // Overflow of counter 0
        force dut.g_cnt[0].cnt_q = 48'hFFFF_FFFF_FFFF;
        #1;
        release dut.g_cnt[0].cnt_q;
        @(negedge clk);
        inc_en = 8'h01;
        @(negedge clk);
        inc_en = 8'h00;
        rd(lo_addr(0), d, h);
`ifdef PERF_CNT_SAT_EN
        check("cnt0_lo_ovf", 64'(d), 64'hFFFF_FFFF);
`else
        check("cnt0_lo_ovf", 64'(d), 64'h0);
`endif
        rd(hi_addr(0), d, h);
`ifdef PERF_CNT_SAT_EN
        check("cnt0_hi_ovf", 64'(d), 64'hFFFF);
`else
        check("cnt0_hi_ovf", 64'(d), 64'h0);
`endif
        rd(BASE + 32'h04, d, h);
        check("ovf_bit0", 64'(d), 64'h1);
        @(negedge clk);
        check("ovf_any_set", 64'(ovf_any), 64'h1);

        // W1C coinciding with a new overflow: set wins
        force dut.g_cnt[0].cnt_q = 48'hFFFF_FFFF_FFFF;
        #1;
        release dut.g_cnt[0].cnt_q;
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_addr = BASE + 32'h04;
        bus.wr_data = 32'h1;
        inc_en      = 8'h01;
        @(negedge clk);
        bus.wr_en = 1'b0;
        inc_en    = 8'h00;
        rd(BASE + 32'h04, d, h);
        check("ovf_set_wins", 64'(d), 64'h1);
        wr(BASE + 32'h04, 32'h1);
        rd(BASE + 32'h04, d, h);
        check("ovf_w1c", 64'(d), 64'h0);
        repeat (2) @(negedge clk);
        check("ovf_any_clr", 64'(ovf_any), 64'h0);

        // Pending overflow on counter 7, then clear with all increments on
        force dut.g_cnt[7].cnt_q = 48'hFFFF_FFFF_FFFF;
        #1;
        release dut.g_cnt[7].cnt_q;
        @(negedge clk);
        inc_en = 8'h80;
        @(negedge clk);
        inc_en = 8'h00;
        rd(BASE + 32'h04, d, h);
        check("ovf_bit7", 64'(d), 64'h80);
        bus.wr_en   = 1'b1;
        bus.wr_addr = BASE;
        bus.wr_data = 32'h3;
        inc_en      = 8'hFF;
        @(negedge clk);
        bus.wr_en = 1'b0;
        @(negedge clk);
        inc_en = 8'h00;
        rd(lo_addr(0), d, h);
        check("clr_resume_cnt0", 64'(d), 64'h1);
        rd(lo_addr(5), d, h);
        check("clr_resume_cnt5", 64'(d), 64'h1);
        rd(lo_addr(1), d, h);
        check("clr_resume_cnt1", 64'(d), 64'h1);
        rd(hi_addr(1), d, h);
        check("clr_hi1", 64'(d), 64'h0);
        rd(BASE + 32'h04, d, h);
        check("clr_ovf", 64'(d), 64'h0);
        rd(BASE, d, h);
        check("clr_ctrl_en", 64'(d), 64'h1);

        // LO read in the same cycle as a clear sees the pre-clear value
        inc_en = 8'h04;
        repeat (9) @(negedge clk);
        inc_en      = 8'h00;
        bus.wr_en   = 1'b1;
        bus.wr_addr = BASE;
        bus.wr_data = 32'h3;
        bus.rd_en   = 1'b1;
        bus.rd_addr = lo_addr(2);
        @(negedge clk);
        check("clr_rd_old", 64'(bus.rd_data), 64'd10);
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        rd(lo_addr(2), d, h);
        check("clr_rd_after", 64'(d), 64'h0);

        // Stores to read-only registers are ignored
        wr(BASE + 32'h08, 32'h0);
        rd(BASE + 32'h08, d, h);
        check("id_ro", 64'(d), 64'h3008_C0DE);
        wr(lo_addr(3), 32'h55);
        rd(lo_addr(3), d, h);
        check("cnt_ro", 64'(d), 64'h0);

        // Asynchronous reset mid-count with a load pending
        force dut.g_cnt[4].cnt_q = 48'hFFFF_FFFF_FFFF;
        #1;
        release dut.g_cnt[4].cnt_q;
        @(negedge clk);
        inc_en = 8'h10;
        @(negedge clk);
        inc_en = 8'h00;
        repeat (2) @(negedge clk);
        check("ovf_any_pre_rst", 64'(ovf_any), 64'h1);
        rd(BASE + 32'h08, d, h);
        bus.rd_en   = 1'b1;
        bus.rd_addr = lo_addr(0);
        inc_en      = 8'hFF;
        #2;
        rst = 1'b0;
        #1;
        check("arst_rd_data", 64'(bus.rd_data), 64'h0);
        check("arst_rd_hit", 64'(bus.rd_hit), 64'h0);
        check("arst_ovf_any", 64'(ovf_any), 64'h0);
        repeat (2) @(negedge clk);
        bus.rd_en = 1'b0;
        inc_en    = 8'h00;
        rst       = 1'b1;
        @(negedge clk);
        rd(BASE, d, h);
        check("arst_ctrl_en", 64'(d), 64'h1);
        rd(lo_addr(4), d, h);
        check("arst_cnt4", 64'(d), 64'h0);
        rd(BASE + 32'h04, d, h);
        check("arst_ovf", 64'(d), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
